// File: rtl/bridge_pkg.sv
// Shared address map, register-file offsets and decode region type for the
// system bridge and its interrupt/fault controller.
package bridge_pkg;

   localparam logic [31:0] DM_LIMIT   = 32'h0000_3000;
   localparam logic [31:0] TMR_BASE   = 32'h0000_7f00;
   localparam logic [31:0] TMR_STRIDE = 32'h0000_0010;
   localparam logic [31:0] TMR_SPAN   = 32'h0000_000c;
   localparam logic [31:0] IC_BASE    = 32'h0000_7f40;
   localparam logic [31:0] IC_SPAN    = 32'h0000_0010;

   localparam logic [1:0] IC_IM    = 2'd0;
   localparam logic [1:0] IC_IP    = 2'd1;
   localparam logic [1:0] IC_ERR   = 2'd2;
   localparam logic [1:0] IC_EADDR = 2'd3;

   localparam int HWINT_W = 6;

   typedef enum logic [1:0] {
      RGN_NONE,
      RGN_DM,
      RGN_TMR,
      RGN_IC
   } region_t;

endpackage

// File: rtl/sys_bridge_ic_irq_ctrl.sv
// Interrupt mask, ext-edge pending bits, registered HWInt vector and sticky
// first-fault capture, plus the combinational read of those registers.
module irq_ctrl
   import bridge_pkg::*;
#(
   parameter int NUM_TIMERS = 2,
   parameter int NUM_EXT    = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            ic_we,
   input  logic [1:0]                      ic_sel,
   input  logic [NUM_TIMERS+NUM_EXT-1:0]   wdata,
   input  logic                            fault,
   input  logic [31:0]                     fault_addr,
   input  logic [NUM_TIMERS-1:0]           tmr_irq,
   input  logic [NUM_EXT-1:0]              ext_irq,
   output logic [31:0]                     rd_word,
   output logic [HWINT_W-1:0]              hwint,
   output logic                            err
);

   localparam int NUM_SRC = NUM_TIMERS + NUM_EXT;

   logic [NUM_SRC-1:0] im;
   logic [NUM_EXT-1:0] ext_prev;
   logic [NUM_EXT-1:0] ext_pend;
   logic [NUM_EXT-1:0] ext_rise;
   logic [NUM_EXT-1:0] ext_clr;
   logic [NUM_SRC-1:0] pend_vec;
   logic [31:0]        eaddr;

   assign ext_rise = ext_irq & ~ext_prev;
   assign ext_clr  = (ic_we && ic_sel == IC_IP) ? wdata[NUM_SRC-1:NUM_TIMERS] : '0;
   assign pend_vec = {ext_pend, tmr_irq};

   always_ff @(posedge clk) begin
      if (!reset) begin
         im       <= '0;
         ext_prev <= '0;
         ext_pend <= '0;
         hwint    <= '0;
         err      <= 1'b0;
         eaddr    <= '0;
      end else begin
         ext_prev <= ext_irq;
         // a new edge beats a simultaneous W1C so no pulse is lost
         ext_pend <= (ext_pend & ~ext_clr) | ext_rise;
         hwint    <= HWINT_W'(pend_vec & im);
         if (ic_we && ic_sel == IC_IM)
            im <= wdata;
         if (fault && !err) begin
            err   <= 1'b1;
            eaddr <= fault_addr;
         end else if (ic_we && ic_sel == IC_ERR) begin
            err <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_word = '0;
      case (ic_sel)
         IC_IM:    rd_word = 32'(im);
         IC_IP:    rd_word = 32'(pend_vec);
         IC_ERR:   rd_word[0] = err;
         default:  rd_word = eaddr;
      endcase
   end

endmodule

// File: rtl/sys_bridge_ic.sv
// CPU data-port bridge: decodes onto DM, timer slaves and the on-bridge
// interrupt/fault register file, and muxes read data back combinationally.
module sys_bridge_ic
   import bridge_pkg::*;
#(
   parameter int          NUM_TIMERS = 2,
   parameter int          NUM_EXT    = 1,
   parameter logic [31:0] DM_LIMIT   = bridge_pkg::DM_LIMIT,
   parameter logic [31:0] TMR_BASE   = bridge_pkg::TMR_BASE,
   parameter logic [31:0] TMR_STRIDE = bridge_pkg::TMR_STRIDE,
   parameter logic [31:0] TMR_SPAN   = bridge_pkg::TMR_SPAN,
   parameter logic [31:0] IC_BASE    = bridge_pkg::IC_BASE
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                cpu_addr,
   input  logic [31:0]                cpu_wdata,
   input  logic [3:0]                 cpu_byteen,
   input  logic                       cpu_re,
   output logic [31:0]                cpu_rdata,
   output logic [HWINT_W-1:0]         cpu_hwint,
   output logic [31:0]                dm_addr,
   output logic [31:0]                dm_wdata,
   output logic [3:0]                 dm_byteen,
   input  logic [31:0]                dm_rdata,
   output logic [29:0]                tmr_addr,
   output logic [31:0]                tmr_din,
   output logic [NUM_TIMERS-1:0]      tmr_we,
   input  logic [32*NUM_TIMERS-1:0]   tmr_dout,
   input  logic [NUM_TIMERS-1:0]      tmr_irq,
   input  logic [NUM_EXT-1:0]         ext_irq,
   output logic                       bus_err
);

   localparam int NUM_SRC = NUM_TIMERS + NUM_EXT;

   if (NUM_SRC > HWINT_W || NUM_TIMERS < 1 || NUM_EXT < 1) begin : g_bad_src
      $error("sys_bridge_ic: NUM_TIMERS+NUM_EXT must fit the 6-bit HWInt vector");
   end

   for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_map_chk
      localparam logic [31:0] T_LO = TMR_BASE + 32'(k) * TMR_STRIDE;
      if (IC_BASE < T_LO + TMR_SPAN && T_LO < IC_BASE + IC_SPAN) begin : g_overlap
         $error("sys_bridge_ic: IC window overlaps a timer window");
      end
   end

   logic                  dm_hit;
   logic                  ic_hit;
   logic [NUM_TIMERS-1:0] tmr_hit;
   logic [31:0]           tmr_rd;
   region_t               region;
   logic                  access;
   logic                  wr_full;
   logic                  illegal;
   logic                  fault;
   logic                  ic_we;
   logic [31:0]           ic_rd;

   always_comb begin
      dm_hit  = cpu_addr < DM_LIMIT;
      ic_hit  = (cpu_addr >= IC_BASE) && (cpu_addr < IC_BASE + IC_SPAN);
      tmr_hit = '0;
      tmr_rd  = '0;
      for (int k = 0; k < NUM_TIMERS; k++) begin
         if (cpu_addr >= TMR_BASE + 32'(k) * TMR_STRIDE &&
             cpu_addr <  TMR_BASE + 32'(k) * TMR_STRIDE + TMR_SPAN) begin
            tmr_hit[k] = 1'b1;
            tmr_rd     = tmr_dout[32*k +: 32];
         end
      end
      region = RGN_NONE;
      if (dm_hit)
         region = RGN_DM;
      else if (|tmr_hit)
         region = RGN_TMR;
      else if (ic_hit)
         region = RGN_IC;
   end

   // peripheral registers only take whole words; partial writes there are faults
   assign access  = cpu_re | (|cpu_byteen);
   assign wr_full = cpu_byteen == 4'hf;
   assign illegal = (|cpu_byteen) && !wr_full && (region == RGN_TMR || region == RGN_IC);
   assign fault   = access && (region == RGN_NONE || illegal);

   assign dm_addr   = cpu_addr;
   assign dm_wdata  = cpu_wdata;
   assign dm_byteen = (region == RGN_DM) ? cpu_byteen : 4'h0;
   assign tmr_addr  = cpu_addr[31:2];
   assign tmr_din   = cpu_wdata;
   assign tmr_we    = wr_full ? tmr_hit : '0;
   assign ic_we     = (region == RGN_IC) && wr_full;

   always_comb begin
      case (region)
         RGN_DM:  cpu_rdata = dm_rdata;
         RGN_TMR: cpu_rdata = tmr_rd;
         RGN_IC:  cpu_rdata = ic_rd;
         default: cpu_rdata = '0;
      endcase
   end

   irq_ctrl #(
      .NUM_TIMERS (NUM_TIMERS),
      .NUM_EXT    (NUM_EXT)
   ) u_irq_ctrl (
      .clk        (clk),
      .reset      (reset),
      .ic_we      (ic_we),
      .ic_sel     (cpu_addr[3:2]),
      .wdata      (cpu_wdata[NUM_SRC-1:0]),
      .fault      (fault),
      .fault_addr (cpu_addr),
      .tmr_irq    (tmr_irq),
      .ext_irq    (ext_irq),
      .rd_word    (ic_rd),
      .hwint      (cpu_hwint),
      .err        (bus_err)
   );

endmodule
